cru_sequencer: RTL

//  Power-up/sleep sequencer for the CRU clock-enable domains (48 MHz, 1.6 MHz, 960 kHz, 32 kHz).

---
 rtl/cru_pkg.sv | 14 +
 rtl/cru_wdog.sv | 29 ++
 rtl/cru_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cru_pkg.sv
// cru_pkg: shared definitions for the CRU clock-enable domain sequencer.
// Domain indices follow the cru enable bus ordering, fastest first.
`timescale 1ns/1ps
package cru_pkg;

   localparam int NDOM   = 4;
   localparam int D_48M  = 0;
   localparam int D_1M6  = 1;
   localparam int D_960K = 2;
   localparam int D_32K  = 3;

   typedef enum logic [2:0] {UP, RUN, DOWN, SLEEP, FAULT} cru_seq_state_t;

endpackage

// File: rtl/cru_wdog.sv
// cru_wdog: tick-timeout counter. Counts clk cycles since the last tick or
// clear and raises expired once CYCLES cycles have elapsed; saturates there.
`timescale 1ns/1ps
module cru_wdog #(
   parameter int CYCLES = 16384
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] r_cnt;

   assign expired = (r_cnt == W'(CYCLES));

   // Restart on any tick or clear, otherwise count up and hold at the limit
   always_ff @(posedge clk) begin
      if (reset || clr || tick) begin
         r_cnt <= '0;
      end else if (!expired) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/cru_sequencer.sv
// cru_sequencer: power-up/sleep sequencer for the four CRU enable domains.
// Releases domains fast-to-slow after reset, parks them slow-to-fast on a
// sleep_req/sleep_ack level handshake. Every mask/reset change happens on a
// tick of the affected domain's own enable.
// Optional watchdog: define CRU_SEQ_WDOG_EN to time out a stage whose enable
// stops ticking; without it fault is tied low and FAULT is unreachable.
`timescale 1ns/1ps
module cru_sequencer
   import cru_pkg::*;
#(
   parameter int HOLD        = 4,
   parameter int WDOG_CYCLES = 16384
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NDOM-1:0] en_i,
   input  logic            sleep_req,
   output logic [NDOM-1:0] en_o,
   output logic [NDOM-1:0] rst_o,
   output logic            ready,
   output logic            sleep_ack,
   output logic            fault
);

   localparam int           CNT_W   = $clog2(HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
   localparam logic [1:0]   LAST    = 2'(NDOM - 1);

   if (HOLD < 1) begin : g_bad_hold
      $error("cru_sequencer: HOLD must be at least 1");
   end
   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("cru_sequencer: WDOG_CYCLES must be at least 1");
   end

   cru_seq_state_t   r_state;
   logic [1:0]       r_stage;
   logic [CNT_W-1:0] r_cnt;
   logic [NDOM-1:0]  r_mask;
   logic [NDOM-1:0]  r_rst;
   logic             r_ready;
   logic             r_ack;

   logic w_tick;
   logic w_expired;

   // Only the enable of the stage currently being sequenced matters
   assign w_tick = en_i[r_stage];

`ifdef CRU_SEQ_WDOG_EN
   logic w_active;
   logic r_fault;

   assign w_active = (r_state == UP) || (r_state == DOWN);

   // Stage changes always coincide with a tick, so tick also covers them
   cru_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (!w_active),
      .tick    (w_tick),
      .expired (w_expired)
   );

   // Fault flag latches on timeout and is cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_active && w_expired) begin
         r_fault <= 1'b1;
      end
   end

   assign fault = r_fault;
`else
   assign w_expired = 1'b0;
   assign fault     = 1'b0;
`endif

   // Sequencer FSM: stage-by-stage release and park, all outputs registered
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all updates see pre-edge values;
      // a blocking '=' would let later lines observe this edge's new state.
      if (reset) begin
         r_state <= UP;
         r_stage <= '0;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_rst   <= '1;
         r_ready <= 1'b0;
         r_ack   <= 1'b0;
      end else if (((r_state == UP) || (r_state == DOWN)) && w_expired) begin
         r_state <= FAULT;
         r_mask  <= '0;
         r_rst   <= '1;
         r_ready <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         case (r_state)
            UP: begin
               if (w_tick) begin
                  if (r_cnt == HOLD_M1) begin
                     r_cnt            <= '0;
                     r_mask[r_stage]  <= 1'b1;
                     r_rst[r_stage]   <= 1'b0;
                     if (r_stage == LAST) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                     end else begin
                        r_stage <= r_stage + 2'd1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            RUN: begin
               if (sleep_req) begin
                  r_ready <= 1'b0;
                  r_state <= DOWN;
                  r_stage <= LAST;
               end
            end
            DOWN: begin
               if (w_tick) begin
                  r_mask[r_stage] <= 1'b0;
                  r_rst[r_stage]  <= 1'b1;
                  if (r_stage == 2'd0) begin
                     r_state <= SLEEP;
                     r_ack   <= 1'b1;
                  end else begin
                     r_stage <= r_stage - 2'd1;
                  end
               end
            end
            SLEEP: begin
               if (!sleep_req) begin
                  r_ack   <= 1'b0;
                  r_state <= UP;
                  r_stage <= '0;
                  r_cnt   <= '0;
               end
            end
            FAULT: ;
            default: ;
         endcase
      end
   end

   // The final tick of a parking domain still passes: mask drops after it
   assign en_o      = en_i & r_mask;
   assign rst_o     = r_rst;
   assign ready     = r_ready;
   assign sleep_ack = r_ack;

endmodule
